// File: rtl/pci32_enum.sv
// pci32_enum: boot-time PCI config-space enumerator.
// Scans function 0 of each slot, sizes BARs 0..2, and enables the devices it finds.
module pci32_enum #(
    parameter logic [7:0]  CFG_BUS   = 8'd0,
    parameter int          NDEV      = 32,
    parameter logic [31:0] MEM_BASE  = 32'h4000_0000,
    parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF,
    parameter int          TIMEOUT   = 16,
    parameter logic [15:0] CMD_VALUE = 16'h0006
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        cs_config_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [5:0]  ndev_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WR_ONES,
        S_RD_MASK,
        S_WR_BAR,
        S_WR_CMD,
        S_NEXT,
        S_FIN
    } state_t;

    state_t      r_state;
    logic [4:0]  r_dev;
    logic [1:0]  r_bar;
    logic [33:0] r_next;
    logic [31:0] r_bar_wdat;
    logic [15:0] r_tmo;
    logic [5:0]  r_ndev;
    logic        r_cs;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_xact;
    logic        w_we;
    logic [3:0]  w_sel;
    logic [5:0]  w_reg;
    logic [31:0] w_dat;
    logic        w_tmo;
    logic        w_fin;
    logic [31:0] w_rdat;
    logic [33:0] w_size;
    logic [33:0] w_aln;
    logic [33:0] w_end;
    logic [33:0] w_nxt;
    logic        w_skip;
    logic        w_ovf;
    logic [5:0]  w_bar_reg;

    assign w_bar_reg = 6'd4 + {4'd0, r_bar};

    always_comb begin
        w_xact = 1'b0;
        w_we   = 1'b0;
        w_sel  = 4'hF;
        w_reg  = 6'd0;
        w_dat  = 32'h0;
        case (r_state)
            S_RD_ID: begin
                w_xact = 1'b1;
            end
            S_WR_ONES: begin
                w_xact = 1'b1;
                w_we   = 1'b1;
                w_reg  = w_bar_reg;
                w_dat  = 32'hFFFF_FFFF;
            end
            S_RD_MASK: begin
                w_xact = 1'b1;
                w_reg  = w_bar_reg;
            end
            S_WR_BAR: begin
                w_xact = 1'b1;
                w_we   = 1'b1;
                w_reg  = w_bar_reg;
                w_dat  = r_bar_wdat;
            end
            S_WR_CMD: begin
                w_xact = 1'b1;
                w_we   = 1'b1;
                w_sel  = 4'h3;
                w_reg  = 6'd1;
                w_dat  = {16'h0, CMD_VALUE};
            end
            default: ;
        endcase
    end

    assign w_tmo  = (r_tmo == 16'(TIMEOUT - 1));
    assign w_fin  = r_cs && (ack_i || w_tmo);
    // A read that never gets acked looks like an empty bus: all ones.
    assign w_rdat = ack_i ? dat_i : 32'hFFFF_FFFF;

    assign w_size = {2'b00, ~(w_rdat & 32'hFFFF_FFF0)} + 34'd1;
    assign w_aln  = (r_next + w_size - 34'd1) & ~(w_size - 34'd1);
    assign w_end  = w_aln + w_size - 34'd1;
    assign w_nxt  = w_aln + w_size;
    assign w_skip = (w_rdat == 32'h0) || w_rdat[0];
    assign w_ovf  = (w_end > {2'b00, MEM_LIMIT});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_dev      <= 5'd0;
            r_bar      <= 2'd0;
            r_next     <= 34'd0;
            r_bar_wdat <= 32'h0;
            r_tmo      <= 16'd0;
            r_ndev     <= 6'd0;
            r_cs       <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Shared transaction engine for every config-access state.
            if (w_xact) begin
                if (!r_cs) begin
                    r_cs  <= 1'b1;
                    r_we  <= w_we;
                    r_sel <= w_sel;
                    r_adr <= {4'h0, CFG_BUS, r_dev, 3'b000,
                              4'h0, w_reg, 2'b00};
                    r_dat <= w_dat;
                    r_tmo <= 16'd0;
                end else if (w_fin) begin
                    r_cs <= 1'b0;
                end else begin
                    r_tmo <= r_tmo + 16'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_dev   <= 5'd0;
                        r_next  <= {2'b00, MEM_BASE};
                        r_ndev  <= 6'd0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RD_ID;
                    end
                end
                S_RD_ID: begin
                    if (w_fin) begin
                        if (w_rdat[15:0] == 16'hFFFF) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_bar   <= 2'd0;
                            r_state <= S_WR_ONES;
                        end
                    end
                end
                S_WR_ONES: begin
                    if (w_fin) r_state <= S_RD_MASK;
                end
                S_RD_MASK: begin
                    if (w_fin) begin
                        if (w_skip) begin
                            r_bar_wdat <= 32'h0;
                        end else if (w_ovf) begin
                            r_bar_wdat <= 32'h0;
                            r_err      <= 1'b1;
                        end else begin
                            r_bar_wdat <= w_aln[31:0];
                            r_next     <= w_nxt;
                        end
                        r_state <= S_WR_BAR;
                    end
                end
                S_WR_BAR: begin
                    if (w_fin) begin
                        r_bar   <= r_bar + 2'd1;
                        r_state <= (r_bar == 2'd2) ? S_WR_CMD : S_WR_ONES;
                    end
                end
                S_WR_CMD: begin
                    if (w_fin) begin
                        r_ndev  <= r_ndev + 6'd1;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_dev == 5'(NDEV - 1)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_dev   <= r_dev + 5'd1;
                        r_state <= S_RD_ID;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cs_config_o = r_cs;
    assign we_o        = r_we;
    assign sel_o       = r_sel;
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign ndev_o      = r_ndev;

endmodule

// File: tb/tb_pci32_enum.sv
// Bench for pci32_enum: slot/BAR responder model, directed table,
// multi-cycle corner sequences and randomized scans against a reference.
module tb_pci32_enum;

    localparam int          NDEV    = 32;
    localparam int          TMO     = 16;
    localparam logic [7:0]  BUS     = 8'h3C;
    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam logic [31:0] LIMIT   = 32'h7FFF_FFFF;
    localparam logic [15:0] CMD     = 16'h0006;
    localparam int          K_ABS   = 0;
    localparam int          K_NORSP = 1;
    localparam int          K_PRES  = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic        cs_config_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [5:0]  ndev_o;

    pci32_enum #(
        .CFG_BUS(BUS), .NDEV(NDEV), .MEM_BASE(BASE),
        .MEM_LIMIT(LIMIT), .TIMEOUT(TMO), .CMD_VALUE(CMD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .cs_config_o(cs_config_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ndev_o(ndev_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          kind    [32];
    logic [31:0] mask    [32][3];
    logic [31:0] barval  [32][3];
    logic [31:0] bar_wr  [32][3];
    int          ones_cnt[32][3];
    int          wr_cnt  [32];
    logic [15:0] cmd_reg [32];
    logic [3:0]  cmd_sel [32];
    int          cmd_cnt [32];

    logic [31:0] exp_bar [32][3];
    bit          exp_pres[32];
    logic        exp_err;
    int          exp_ndev;

    typedef struct {
        int          slot;
        logic [31:0] m0, m1, m2;
        logic [31:0] e0, e1, e2;
        logic        err;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Config-space responder: random ack latency, NORSP slots never ack.
    int lat = 0;
    int lat_cnt = 0;
    always @(negedge clk) begin : resp
        int d;
        int r;
        if (!cs_config_o) begin
            ack_i   = 1'b0;
            lat_cnt = 0;
            lat     = $urandom_range(0, 3);
        end else if (!ack_i) begin
            d = int'(adr_o[19:15]);
            r = int'(adr_o[7:2]);
            if (kind[d] != K_NORSP) begin
                if (lat_cnt < lat) begin
                    lat_cnt++;
                end else begin
                    ack_i = 1'b1;
                    if (we_o) begin
                        wr_cnt[d]++;
                        if (r >= 4 && r <= 6) begin
                            bar_wr[d][r-4] = dat_o;
                            barval[d][r-4] = dat_o & mask[d][r-4];
                            if (dat_o == 32'hFFFF_FFFF) ones_cnt[d][r-4]++;
                        end else if (r == 1) begin
                            cmd_reg[d] = dat_o[15:0];
                            cmd_sel[d] = sel_o;
                            cmd_cnt[d]++;
                        end
                    end else if (r == 0) begin
                        dat_i = (kind[d] == K_PRES) ? 32'hABCD_1234 : 32'hFFFF_FFFF;
                    end else if (r >= 4 && r <= 6) begin
                        dat_i = barval[d][r-4];
                    end else begin
                        dat_i = 32'h0;
                    end
                end
            end
        end else begin
            ack_i = 1'b0;
        end
    end

    // Protocol monitor: stability, address fields, lanes, done/busy, timeout length.
    int          prot_err = 0;
    int          done_cnt = 0;
    int          run_len = 0;
    int          to_run = 0;
    logic        pcs = 1'b0;
    logic        pbusy = 1'b0;
    logic        pwe = 1'b0;
    logic [3:0]  psel = 4'h0;
    logic [31:0] padr = 32'h0;
    logic [31:0] pdat = 32'h0;
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (done_o && busy_o) prot_err++;
        if (pbusy && !busy_o && !done_o && rst_ni) prot_err++;
        if (cs_config_o) begin
            if (pcs && (adr_o != padr || dat_o != pdat || we_o != pwe || sel_o != psel))
                prot_err++;
            if (adr_o[31:28] != 4'h0 || adr_o[27:20] != BUS ||
                adr_o[14:8] != 7'h0 || adr_o[1:0] != 2'b00)
                prot_err++;
            if (sel_o != ((we_o && adr_o[7:2] == 6'd1) ? 4'h3 : 4'hF))
                prot_err++;
            run_len++;
            if (kind[adr_o[19:15]] == K_NORSP) to_run = run_len;
        end else begin
            run_len = 0;
        end
        pcs   = cs_config_o;
        pbusy = busy_o;
        pwe   = we_o;
        psel  = sel_o;
        padr  = adr_o;
        pdat  = dat_o;
    end

    task automatic set_all_absent();
        for (int d = 0; d < 32; d++) begin
            kind[d] = K_ABS;
            exp_pres[d] = 1'b0;
            for (int b = 0; b < 3; b++) begin
                mask[d][b]    = 32'h0;
                exp_bar[d][b] = 32'h0;
            end
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 32; d++) begin
            wr_cnt[d]  = 0;
            cmd_reg[d] = 16'h0;
            cmd_sel[d] = 4'h0;
            cmd_cnt[d] = 0;
            for (int b = 0; b < 3; b++) begin
                barval[d][b]   = 32'h0;
                bar_wr[d][b]   = 32'hDEAD_BEEF;
                ones_cnt[d][b] = 0;
            end
        end
    endtask

    // Reference: BAR size is the lowest implemented address bit; address is
    // next_addr rounded up to a multiple of the size.
    task automatic ref_scan();
        longint nxt;
        longint s;
        longint a;
        logic [31:0] m;
        nxt = longint'(BASE);
        exp_err = 1'b0;
        exp_ndev = 0;
        for (int d = 0; d < NDEV; d++) begin
            exp_pres[d] = (kind[d] == K_PRES);
            if (exp_pres[d]) begin
                exp_ndev++;
                for (int b = 0; b < 3; b++) begin
                    m = mask[d][b];
                    exp_bar[d][b] = 32'h0;
                    if (m != 32'h0 && !m[0]) begin
                        s = 16;
                        while (s < 64'h1_0000_0000 && (longint'(m) & s) == 0)
                            s = s * 2;
                        a = ((nxt + s - 1) / s) * s;
                        if (a + s - 1 > longint'(LIMIT)) begin
                            exp_err = 1'b1;
                        end else begin
                            exp_bar[d][b] = a[31:0];
                            nxt = a + s;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_scan(string tag);
        int n;
        clear_logs();
        done_cnt = 0;
        prot_err = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, " busy_rise"}, longint'(busy_o), 1);
        chk({tag, " err_clr"}, longint'(err_o), 0);
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, " done_pulses"}, longint'(done_cnt), 1);
        chk({tag, " busy_fall"}, longint'(busy_o), 0);
        chk({tag, " protocol"}, longint'(prot_err), 0);
    endtask

    task automatic check_result(string tag);
        for (int d = 0; d < NDEV; d++) begin
            if (exp_pres[d]) begin
                for (int b = 0; b < 3; b++) begin
                    chk($sformatf("%s bar d%0d b%0d", tag, d, b),
                        longint'(bar_wr[d][b]), longint'(exp_bar[d][b]));
                    chk($sformatf("%s ones d%0d b%0d", tag, d, b),
                        longint'(ones_cnt[d][b]), 1);
                end
                chk($sformatf("%s cmd d%0d", tag, d), longint'(cmd_reg[d]), longint'(CMD));
                chk($sformatf("%s sel d%0d", tag, d), longint'(cmd_sel[d]), 3);
                chk($sformatf("%s cmdcnt d%0d", tag, d), longint'(cmd_cnt[d]), 1);
                chk($sformatf("%s wrcnt d%0d", tag, d), longint'(wr_cnt[d]), 7);
            end else begin
                chk($sformatf("%s nowr d%0d", tag, d), longint'(wr_cnt[d]), 0);
            end
        end
        chk({tag, " ndev"}, longint'(ndev_o), longint'(exp_ndev));
        chk({tag, " err"}, longint'(err_o), longint'(exp_err));
    endtask

    function automatic logic [31:0] rand_mask();
        logic [31:0] m;
        int k;
        case ($urandom_range(0, 6))
            0: m = 32'h0;
            1: m = 32'hFFFF_FF01;
            2: m = 32'h0000_0008;
            3: begin
                k = $urandom_range(28, 31);
                m = 32'hFFFF_FFFF << k;
            end
            default: begin
                k = $urandom_range(4, 24);
                m = (32'hFFFF_FFFF << k) | ($urandom_range(0, 1) != 0 ? 32'h8 : 32'h0);
            end
        endcase
        return m;
    endfunction

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        set_all_absent();
        clear_logs();
        tbl[0] = '{2,  32'hFFF0_0000, 32'h0, 32'h0,
                   32'h4000_0000, 32'h0, 32'h0, 1'b0};
        tbl[1] = '{0,  32'hFFFF_FF01, 32'hFFFF_F000, 32'h0,
                   32'h0, 32'h4000_0000, 32'h0, 1'b0};
        tbl[2] = '{31, 32'h8000_0000, 32'hFFFF_FFF0, 32'h0,
                   32'h0, 32'h4000_0000, 32'h0, 1'b1};
        tbl[3] = '{5,  32'hFFFF_F000, 32'hFFF0_0008, 32'hFFFF_FFF0,
                   32'h4000_0000, 32'h4010_0000, 32'h4020_0000, 1'b0};
        tbl[4] = '{7,  32'hC000_0000, 32'hC000_0000, 32'h0,
                   32'h4000_0000, 32'h0, 32'h0, 1'b1};

        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            longint'({cs_config_o, we_o, sel_o, adr_o, dat_o,
                      busy_o, done_o, err_o, ndev_o}), 0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            set_all_absent();
            kind[tbl[i].slot]    = K_PRES;
            mask[tbl[i].slot][0] = tbl[i].m0;
            mask[tbl[i].slot][1] = tbl[i].m1;
            mask[tbl[i].slot][2] = tbl[i].m2;
            exp_pres[tbl[i].slot]   = 1'b1;
            exp_bar[tbl[i].slot][0] = tbl[i].e0;
            exp_bar[tbl[i].slot][1] = tbl[i].e1;
            exp_bar[tbl[i].slot][2] = tbl[i].e2;
            exp_err  = tbl[i].err;
            exp_ndev = 1;
            run_scan($sformatf("tbl%0d", i));
            check_result($sformatf("tbl%0d", i));
        end

        // Two devices: 4 KB then 1 MB, second aligned up from 4000_1000.
        set_all_absent();
        kind[1] = K_PRES;
        mask[1][0] = 32'hFFFF_F000;
        kind[4] = K_PRES;
        mask[4][0] = 32'hFFF0_0000;
        exp_pres[1] = 1'b1;
        exp_pres[4] = 1'b1;
        exp_bar[1][0] = 32'h4000_0000;
        exp_bar[4][0] = 32'h4010_0000;
        exp_err = 1'b0;
        exp_ndev = 2;
        run_scan("two");
        check_result("two");

        // Slot with no responder ahead of a real device.
        set_all_absent();
        kind[3] = K_NORSP;
        kind[6] = K_PRES;
        mask[6][0] = 32'hFFFF_0000;
        exp_pres[6] = 1'b1;
        exp_bar[6][0] = 32'h4000_0000;
        exp_err = 1'b0;
        exp_ndev = 1;
        to_run = 0;
        run_scan("norsp");
        check_result("norsp");
        chk("norsp timeout_len", longint'(to_run), longint'(TMO));

        // Reset during the BAR0 mask read, then a clean rescan.
        set_all_absent();
        kind[0] = K_PRES;
        mask[0][0] = 32'hFFF0_0000;
        mask[0][1] = 32'hFFFF_F000;
        clear_logs();
        done_cnt = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(cs_config_o && !we_o && adr_o[7:2] == 6'd4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst reached_rd_mask", longint'(n < 500), 1);
        rst_ni = 1'b0;
        #1;
        chk("rst cs_drop", longint'(cs_config_o), 0);
        chk("rst outputs",
            longint'({cs_config_o, we_o, sel_o, adr_o, dat_o,
                      busy_o, done_o, err_o, ndev_o}), 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst no_done", longint'(done_cnt), 0);
        chk("rst idle", longint'(busy_o), 0);
        ref_scan();
        run_scan("rescan");
        check_result("rescan");
        chk("rescan bar0", longint'(bar_wr[0][0]), longint'(32'h4000_0000));
        chk("rescan bar1", longint'(bar_wr[0][1]), longint'(32'h4010_0000));

        for (int t = 0; t < 6; t++) begin
            set_all_absent();
            for (int d = 0; d < NDEV; d++) begin
                n = $urandom_range(0, 19);
                kind[d] = (n < 12) ? K_ABS : (n < 13) ? K_NORSP : K_PRES;
                for (int b = 0; b < 3; b++) mask[d][b] = rand_mask();
            end
            ref_scan();
            run_scan($sformatf("rnd%0d", t));
            check_result($sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
